// File: rtl/pong_pixel_gen.sv
// pong_pixel_gen: once-per-frame pong game engine (paddle, ball, score, FSM)
// and registered 12-bit pixel colouring for the 640x480 display area.
module pong_pixel_gen #(
  parameter int PAD_H       = 72,
  parameter int PAD_V       = 3,
  parameter int BALL_V      = 2,
  parameter int MISS_FRAMES = 60
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] rgb,
  output logic [7:0]  score,
  output logic [1:0]  game_state
);

  // Geometry, all in 11 bits so sums never wrap.
  localparam logic [10:0] H_LAST      = 11'd639;
  localparam logic [10:0] V_ACT       = 11'd480;
  localparam logic [10:0] PAD_X_L     = 11'd600;
  localparam logic [10:0] PAD_X_R     = 11'd603;
  localparam logic [10:0] WALL_X_L    = 11'd32;
  localparam logic [10:0] WALL_X_R    = 11'd39;
  localparam logic [10:0] WALL_BOUNCE = 11'd40;
  localparam logic [10:0] BALL_SZ     = 11'd8;
  localparam logic [10:0] BALL_LAST   = 11'd7;
  localparam logic [10:0] PAD_H_W     = 11'(PAD_H);
  localparam logic [10:0] PAD_V_W     = 11'(PAD_V);
  localparam logic [10:0] BALL_V_W    = 11'(BALL_V);
  localparam logic [10:0] PAD_Y_MAX   = V_ACT - PAD_H_W;

  localparam logic [9:0] PAD_V_10     = 10'(PAD_V);
  localparam logic [9:0] BALL_V_10    = 10'(BALL_V);
  localparam logic [9:0] PAD_Y_MAX_10 = 10'(480 - PAD_H);
  localparam logic [9:0] PAD_Y_RST    = 10'((480 - PAD_H) / 2);
  localparam logic [9:0] BALL_X_RST   = 10'd320;
  localparam logic [9:0] BALL_Y_RST   = 10'd240;

  localparam int CNT_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_MISS = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       pad_y_q, pad_y_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic             dx_neg_q, dx_neg_d;   // 1: ball moving left
  logic             dy_neg_q, dy_neg_d;   // 1: ball moving up
  logic [7:0]       score_q, score_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic        frame_tick;
  logic [10:0] pad_ext, bx_ext, by_ext, x_ext, y_ext;
  logic        top_hit, bot_hit, wall_hit, pad_hit, ball_miss;
  logic        dx_neg_new, dy_neg_new;
  logic [9:0]  pad_y_move;
  logic [7:0]  score_inc;
  logic        in_ball, in_pad, in_wall;
  logic [11:0] pixel_d;

  // One pulse per frame, in vertical blanking, so positions never change mid-frame.
  assign frame_tick = p_tick && (x == 10'd0) && (y == 10'd481);

  assign pad_ext = {1'b0, pad_y_q};
  assign bx_ext  = {1'b0, ball_x_q};
  assign by_ext  = {1'b0, ball_y_q};
  assign x_ext   = {1'b0, x};
  assign y_ext   = {1'b0, y};

  // Collision terms evaluated against the current (pre-update) positions.
  assign top_hit   = by_ext < BALL_V_W;
  assign bot_hit   = (by_ext + BALL_SZ) > (V_ACT - BALL_V_W);
  assign wall_hit  = bx_ext <= WALL_BOUNCE;
  assign pad_hit   = !dx_neg_q
                  && ((bx_ext + BALL_LAST) >= PAD_X_L)
                  && ((bx_ext + BALL_LAST) <= PAD_X_R)
                  && ((by_ext + BALL_LAST) >= pad_ext)
                  && (by_ext <= (pad_ext + PAD_H_W - 11'd1));
  assign ball_miss = (bx_ext + BALL_LAST) > H_LAST;

  // A paddle hit overrides the wall; top/bottom is independent, so a corner flips both.
  assign dy_neg_new = top_hit ? 1'b0 : (bot_hit ? 1'b1 : dy_neg_q);
  assign dx_neg_new = pad_hit ? 1'b1 : (wall_hit ? 1'b0 : dx_neg_q);

  // Paddle step with clamping at the top and bottom of the display.
  always_comb begin
    pad_y_move = pad_y_q;
    if (btn_up && !btn_down) begin
      pad_y_move = (pad_ext < PAD_V_W) ? 10'd0 : pad_y_q - PAD_V_10;
    end else if (btn_down && !btn_up) begin
      pad_y_move = ((pad_ext + PAD_V_W) > PAD_Y_MAX) ? PAD_Y_MAX_10 : pad_y_q + PAD_V_10;
    end
  end

  // Two-digit BCD increment, 99 wraps to 00.
  always_comb begin
    score_inc = score_q;
    if (score_q[3:0] == 4'd9) begin
      if (score_q[7:4] == 4'd9) begin
        score_inc = 8'h00;
      end else begin
        score_inc = {score_q[7:4] + 4'd1, 4'd0};
      end
    end else begin
      score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
    end
  end

  // Next-state and next game values; everything holds unless frame_tick.
  always_comb begin
    state_d    = state_q;
    pad_y_d    = pad_y_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    dx_neg_d   = dx_neg_q;
    dy_neg_d   = dy_neg_q;
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;
    if (frame_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (btn_up || btn_down) begin
            state_d = S_PLAY;
            score_d = 8'h00;
          end
        end
        S_PLAY: begin
          pad_y_d = pad_y_move;
          if (ball_miss) begin
            state_d    = S_MISS;
            miss_cnt_d = '0;
          end else begin
            dx_neg_d = dx_neg_new;
            dy_neg_d = dy_neg_new;
            ball_x_d = dx_neg_new ? ball_x_q - BALL_V_10 : ball_x_q + BALL_V_10;
            ball_y_d = dy_neg_new ? ball_y_q - BALL_V_10 : ball_y_q + BALL_V_10;
            if (pad_hit) begin
              score_d = score_inc;
            end
          end
        end
        S_MISS: begin
          if (miss_cnt_q == CNT_LAST) begin
            state_d  = S_IDLE;
            ball_x_d = BALL_X_RST;
            ball_y_d = BALL_Y_RST;
            dx_neg_d = 1'b1;
            dy_neg_d = 1'b0;
          end else begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Game datapath registers: paddle, ball, directions, score, miss counter.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      pad_y_q    <= PAD_Y_RST;
      ball_x_q   <= BALL_X_RST;
      ball_y_q   <= BALL_Y_RST;
      dx_neg_q   <= 1'b1;
      dy_neg_q   <= 1'b0;
      score_q    <= 8'h00;
      miss_cnt_q <= '0;
    end else begin
      pad_y_q    <= pad_y_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      dx_neg_q   <= dx_neg_d;
      dy_neg_q   <= dy_neg_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign in_ball = (x_ext >= bx_ext) && (x_ext < (bx_ext + BALL_SZ))
                && (y_ext >= by_ext) && (y_ext < (by_ext + BALL_SZ));
  assign in_pad  = (x_ext >= PAD_X_L) && (x_ext <= PAD_X_R)
                && (y_ext >= pad_ext) && (y_ext < (pad_ext + PAD_H_W));
  assign in_wall = (x_ext >= WALL_X_L) && (x_ext <= WALL_X_R);

  // Pixel colour by priority: ball, paddle, wall, background.
  always_comb begin
    pixel_d = 12'h000;
    if (video_on) begin
      if (in_ball) begin
        pixel_d = 12'hF00;
      end else if (in_pad) begin
        pixel_d = 12'h0F0;
      end else if (in_wall) begin
        pixel_d = 12'h00F;
      end
    end
  end

  // Colour register, updated every clock.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= 12'h000;
    end else begin
      rgb <= pixel_d;
    end
  end

  assign score      = score_q;
  assign game_state = state_q;

endmodule
